// File: rtl/sum_entry_controller.sv
// rtl/sum_entry_controller.sv - keypad-driven two-operand decimal addition sequencer
module sum_entry_controller #(
   parameter int MAX_DIGITS     = 3,
   parameter int WIDTH          = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_valid,
   input  logic [3:0]       key_code,
   input  logic [WIDTH-1:0] adder_sum,
   input  logic             adder_valid,
   output logic             adder_enable,
   output logic [WIDTH-1:0] number1,
   output logic [WIDTH-1:0] number2,
   output logic [WIDTH-1:0] display_value,
   output logic             result_valid,
   output logic             entering_b,
   output logic             busy,
   output logic             error
);
   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int EW = WIDTH + 4;
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_DIGITS);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [EW-1:0] TEN      = EW'(10);

   typedef enum logic [2:0] {ENTRY_A, ENTRY_B, REQ, WAIT, SHOW} state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt_a, cnt_b, ca_nx, cb_nx;
   logic [TW-1:0]   tmr, tmr_nx;
   logic [WIDTH-1:0] n1_nx, n2_nx, disp_nx;
   logic            rv_nx, err_nx;

   logic key_digit, key_plus, key_eq, key_clr, timed_out;
   assign key_digit = key_valid && (key_code <= 4'd9);
   assign key_plus  = key_valid && (key_code == 4'hA);
   assign key_eq    = key_valid && (key_code == 4'hB);
   assign key_clr   = key_valid && (key_code == 4'hC);
   assign timed_out = (tmr == TMR_LAST);

   // Shift-in of a new digit, computed wide and truncated back to WIDTH
   logic [WIDTH-1:0] key_ext;
   logic [EW-1:0]    prod_a, prod_b;
   logic             unused_ovf;
   assign key_ext    = {{(WIDTH-4){1'b0}}, key_code};
   assign prod_a     = {4'd0, number1} * TEN + {4'd0, key_ext};
   assign prod_b     = {4'd0, number2} * TEN + {4'd0, key_ext};
   assign unused_ovf = ^{prod_a[EW-1:WIDTH], prod_b[EW-1:WIDTH]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ENTRY_A;
      else       state <= state_nx;
   end

   // Next-state selection; clear overrides everything
   always_comb begin
      state_nx = state;
      if (key_clr) begin
         state_nx = ENTRY_A;
      end else begin
         case (state)
            ENTRY_A: if (key_plus) state_nx = ENTRY_B;
                     else if (key_eq) state_nx = REQ;
            ENTRY_B: if (key_eq) state_nx = REQ;
            REQ:     state_nx = WAIT;
            WAIT:    if (adder_valid || timed_out) state_nx = SHOW;
            SHOW:    if (key_digit) state_nx = ENTRY_A;
                     else if (key_plus) state_nx = ENTRY_B;
                     else if (key_eq) state_nx = REQ;
            default: state_nx = ENTRY_A;
         endcase
      end
   end

   // State-decoded outputs
   always_comb begin
      adder_enable = (state == REQ);
      busy         = (state == REQ) || (state == WAIT);
      entering_b   = (state == ENTRY_B);
   end

   // Next values of operands, digit counts, display and status flags
   always_comb begin
      n1_nx   = number1;
      n2_nx   = number2;
      ca_nx   = cnt_a;
      cb_nx   = cnt_b;
      disp_nx = display_value;
      rv_nx   = result_valid;
      err_nx  = error;
      tmr_nx  = '0;
      if (key_clr) begin
         n1_nx   = '0;
         n2_nx   = '0;
         ca_nx   = '0;
         cb_nx   = '0;
         disp_nx = '0;
         rv_nx   = 1'b0;
         err_nx  = 1'b0;
      end else begin
         case (state)
            ENTRY_A: begin
               if (key_digit && (cnt_a != CNT_MAX)) begin
                  n1_nx   = prod_a[WIDTH-1:0];
                  ca_nx   = cnt_a + CW'(1);
                  disp_nx = prod_a[WIDTH-1:0];
               end else if (key_plus) begin
                  n2_nx   = '0;
                  cb_nx   = '0;
                  disp_nx = '0;
               end else if (key_eq) begin
                  n2_nx   = '0;
               end
            end
            ENTRY_B: begin
               if (key_digit && (cnt_b != CNT_MAX)) begin
                  n2_nx   = prod_b[WIDTH-1:0];
                  cb_nx   = cnt_b + CW'(1);
                  disp_nx = prod_b[WIDTH-1:0];
               end
            end
            WAIT: begin
               tmr_nx = tmr + TW'(1);
               if (adder_valid) begin
                  disp_nx = adder_sum;
                  rv_nx   = 1'b1;
               end else if (timed_out) begin
                  disp_nx = '0;
                  rv_nx   = 1'b0;
                  err_nx  = 1'b1;
               end
            end
            SHOW: begin
               if (key_digit) begin
                  n1_nx   = key_ext;
                  n2_nx   = '0;
                  ca_nx   = CW'(1);
                  cb_nx   = '0;
                  disp_nx = key_ext;
                  rv_nx   = 1'b0;
                  err_nx  = 1'b0;
               end else if (key_plus) begin
                  n2_nx   = '0;
                  cb_nx   = '0;
                  disp_nx = '0;
                  rv_nx   = 1'b0;
                  err_nx  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         number1       <= '0;
         number2       <= '0;
         cnt_a         <= '0;
         cnt_b         <= '0;
         display_value <= '0;
         result_valid  <= 1'b0;
         error         <= 1'b0;
         tmr           <= '0;
      end else begin
         number1       <= n1_nx;
         number2       <= n2_nx;
         cnt_a         <= ca_nx;
         cnt_b         <= cb_nx;
         display_value <= disp_nx;
         result_valid  <= rv_nx;
         error         <= err_nx;
         tmr           <= tmr_nx;
      end
   end
endmodule

// File: tb/tb_sum_entry_controller.sv
// tb/tb_sum_entry_controller.sv - directed and randomized checks of sum_entry_controller
module tb_sum_entry_controller;
   localparam int MAXD = 3;
   localparam int W    = 12;
   localparam int TO   = 16;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         key_valid = 1'b0;
   logic [3:0]   key_code = 4'h0;
   logic [W-1:0] adder_sum = '0;
   logic         adder_valid = 1'b0;
   logic         adder_enable;
   logic [W-1:0] number1, number2, display_value;
   logic         result_valid, entering_b, busy, error;

   sum_entry_controller #(.MAX_DIGITS(MAXD), .WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .adder_sum(adder_sum), .adder_valid(adder_valid), .adder_enable(adder_enable),
      .number1(number1), .number2(number2), .display_value(display_value),
      .result_valid(result_valid), .entering_b(entering_b), .busy(busy), .error(error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int enable_count = 0;
   bit adder_live = 1'b1;
   bit fire_next = 1'b0;
   logic [W-1:0] pend_sum = '0;

   // adder model: one-cycle latency, operands captured while enable is high
   always @(negedge clk) begin
      adder_valid = 1'b0;
      if (fire_next) begin
         adder_valid = 1'b1;
         adder_sum   = pend_sum;
      end
      fire_next = adder_enable && adder_live && !reset;
      if (adder_enable) begin
         pend_sum = number1 + number2;
         enable_count++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " number1"}, 32'(number1), 0);
      check({tag, " number2"}, 32'(number2), 0);
      check({tag, " display"}, 32'(display_value), 0);
      check({tag, " enable"}, 32'(adder_enable), 0);
      check({tag, " result_valid"}, 32'(result_valid), 0);
      check({tag, " entering_b"}, 32'(entering_b), 0);
      check({tag, " busy"}, 32'(busy), 0);
      check({tag, " error"}, 32'(error), 0);
   endtask

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic do_equals(input string tag, input int exp_sum);
      int e0;
      int b;
      e0 = enable_count;
      press(4'hB);
      b = 0;
      while (busy === 1'b1 && b < 64) begin
         b++;
         @(negedge clk);
      end
      check({tag, " busy_len_ok"}, 32'(b >= 2 && b <= 3), 1);
      check({tag, " enable_pulses"}, 32'(enable_count - e0), 1);
      check({tag, " display"}, 32'(display_value), exp_sum);
      check({tag, " result_valid"}, 32'(result_valid), 1);
      check({tag, " error"}, 32'(error), 0);
   endtask

   // random digit string; operand is its value with digits beyond MAXD dropped
   task automatic enter_rand(input int len, output int val);
      int full;
      int d;
      full = 0;
      for (int i = 0; i < len; i++) begin
         d = $urandom_range(0, 9);
         press(4'(d));
         full = full * 10 + d;
      end
      val = (len > MAXD) ? full / (10 ** (len - MAXD)) : full;
   endtask

   initial begin
      int a, b, e0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      press(4'd3); press(4'd6); press(4'd7);
      check("t1 n1", 32'(number1), 367);
      check("t1 disp_a", 32'(display_value), 367);
      press(4'hA);
      check("t1 entering_b", 32'(entering_b), 1);
      check("t1 n2_clr", 32'(number2), 0);
      press(4'd9); press(4'd8); press(4'hA); press(4'd0);
      check("t1 n2", 32'(number2), 980);
      check("t1 disp_b", 32'(display_value), 980);
      check("t1 still_b", 32'(entering_b), 1);
      do_equals("t1", 1347);
      check("t1 n1_held", 32'(number1), 367);
      check("t1 n2_held", 32'(number2), 980);

      press(4'hC);
      check("clr n1", 32'(number1), 0);
      check("clr disp", 32'(display_value), 0);
      check("clr rv", 32'(result_valid), 0);
      press(4'd1); press(4'd2); press(4'hE); press(4'd3); press(4'd4);
      check("t2 n1", 32'(number1), 123);
      press(4'hA); press(4'd5);
      do_equals("t2", 128);

      press(4'hC); press(4'd4);
      do_equals("t3a", 4);
      check("t3a n2", 32'(number2), 0);
      do_equals("t3b", 4);
      press(4'd7);
      check("t3 n1", 32'(number1), 7);
      check("t3 rv", 32'(result_valid), 0);
      check("t3 entry_a", 32'(entering_b), 0);
      check("t3 disp", 32'(display_value), 7);
      press(4'd8); press(4'd9); press(4'd1);
      check("t3 n1_cap", 32'(number1), 789);
      do_equals("t3c", 789);
      press(4'hA);
      check("show_plus n1", 32'(number1), 789);
      check("show_plus eb", 32'(entering_b), 1);
      check("show_plus rv", 32'(result_valid), 0);
      press(4'd2); press(4'd1);
      do_equals("t3d", 810);

      // adder never responds
      press(4'hC); press(4'd5);
      adder_live = 1'b0;
      press(4'hB);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         key_valid = (i == 4);
         key_code  = 4'd3;
      end
      key_valid = 1'b0;
      check("to early_err", 32'(error), 0);
      check("to busy", 32'(busy), 1);
      @(negedge clk);
      check("to err", 32'(error), 1);
      check("to rv", 32'(result_valid), 0);
      check("to disp", 32'(display_value), 0);
      check("to n1_kept", 32'(number1), 5);
      press(4'hC);
      check("to clr_err", 32'(error), 0);
      adder_live = 1'b1;

      // clear presented during REQ
      press(4'd2);
      e0 = enable_count;
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = 4'hB;
      @(negedge clk);
      key_code  = 4'hC;
      check("creq enable", 32'(adder_enable), 1);
      @(negedge clk);
      key_valid = 1'b0;
      check("creq enable_low", 32'(adder_enable), 0);
      check("creq busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("creq disp", 32'(display_value), 0);
      check("creq rv", 32'(result_valid), 0);
      check("creq pulses", 32'(enable_count - e0), 1);

      for (int it = 0; it < 10; it++) begin
         press(4'hC);
         enter_rand($urandom_range(1, 5), a);
         check("rnd n1", 32'(number1), a);
         b = 0;
         if ($urandom_range(0, 1) == 1) begin
            press(4'hA);
            enter_rand($urandom_range(1, 5), b);
            check("rnd n2", 32'(number2), b);
         end
         do_equals("rnd", a + b);
      end

      // asynchronous reset in WAIT
      press(4'hC); press(4'd6);
      adder_live = 1'b0;
      press(4'hB);
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      reset = 1'b0;
      adder_live = 1'b1;
      press(4'd5);
      check("post_rst n1", 32'(number1), 5);
      check("post_rst disp", 32'(display_value), 5);
      check("post_rst busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sum_entry_controller.md
Name: sum_entry_controller

Overview:
- Sequences a two-operand decimal addition from single-key events (digits and command codes) produced by the keypad reader.
- Accumulates operand A and operand B (up to MAX_DIGITS decimal digits each) and drives the shared adder_submodule through its enable/valid handshake.
- Latches the sum when the adder reports valid and presents the current value for the display path.
- Sits between the keypad decoder and the adder/display blocks in the 27 MHz domain.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits accepted per operand; excess digits are ignored. The operand limit is 10^MAX_DIGITS-1.
- WIDTH, 12, width of the operand, sum and display buses.
- TIMEOUT_CYCLES, 16, clock cycles to wait for adder valid before flagging an error.

Ports:
- clk  input  1  system clock, 27 MHz
- reset  input  1  asynchronous, active-high reset
- key_valid  input  1  one-cycle strobe; key_code is valid in the same cycle
- key_code  input  4  0x0-0x9 digit; 0xA '+'; 0xB '='; 0xC clear; 0xD-0xF ignored
- adder_sum  input  WIDTH  sum_result from the adder
- adder_valid  input  1  sum_state from the adder
- adder_enable  output  1  enable to the adder
- number1  output  WIDTH  operand A to the adder
- number2  output  WIDTH  operand B to the adder
- display_value  output  WIDTH  value to show
- result_valid  output  1  high while a latched sum is shown
- entering_b  output  1  high in ENTRY_B
- busy  output  1  high in REQ or WAIT
- error  output  1  adder timeout occurred; sticky until clear or a new entry

Behaviour:
- Reset is asynchronous and active-high. On reset: state=ENTRY_A and every output is 0 (number1, number2, display_value, adder_enable, result_valid, entering_b, busy, error); the digit counters and timeout counter are also cleared.
- States: ENTRY_A, ENTRY_B, REQ, WAIT, SHOW. Every transition takes effect on a clk rising edge.
- Digit rule, ENTRY_A and ENTRY_B only: active operand <= operand*10 + digit, and its digit count increments.
  - If the count already equals MAX_DIGITS, the digit is ignored.
  - A leading 0 counts as a digit.
  - The multiply-by-10 is computed at WIDTH+4 bits and truncated. With the default parameters the operand never exceeds 999.
- ENTRY_A transitions:
  - '+' -> ENTRY_B, with number2 and its digit count cleared.
  - '=' -> REQ, with number2 held at 0.
- ENTRY_B transitions:
  - '+' is ignored.
  - '=' -> REQ.
- REQ: adder_enable=1 for exactly this one cycle, then -> WAIT. number1 and number2 are held stable from REQ until SHOW.
- WAIT:
  - adder_enable=0; the timeout counter increments each cycle.
  - adder_valid=1 -> at the next edge latch adder_sum into display_value, set result_valid=1, go to SHOW.
  - If adder_valid has not been seen after TIMEOUT_CYCLES cycles in WAIT -> SHOW with error=1, result_valid=0, display_value=0.
  - The timeout test is counter==TIMEOUT_CYCLES-1, evaluated in the same cycle that adder_valid is checked. If both are true in one cycle, adder_valid wins.
- SHOW:
  - A digit starts a new calculation: number1=digit, number2=0, counts reset with A's count set to 1, result_valid=0, error=0, -> ENTRY_A.
  - '+' -> ENTRY_B, keeping number1 (A's count is unchanged), clearing number2, result_valid=0, error=0.
  - '=' repeats the request: -> REQ with the same operands.
- display_value outside SHOW: equals number1 in ENTRY_A and number2 in ENTRY_B. In REQ and WAIT it holds its previous value.
- Clear (0xC) in any state:
  - Next edge -> ENTRY_A, with all operands, counters, display_value, result_valid and error cleared.
  - If clear arrives in REQ, adder_enable drops at that edge, so no extra enable is issued.
  - A late adder_valid arriving after a clear is ignored.
- Key events other than clear are ignored in REQ and WAIT (no queuing).
- busy = (state is REQ or WAIT). entering_b = (state is ENTRY_B).
- Arithmetic: WIDTH must hold 2*(10^MAX_DIGITS-1); the default 999+999=1998 fits in 12 bits.

Test Plan:
- Reset mid-WAIT -> all outputs 0 in the same cycle (asynchronous); state ENTRY_A after release.
- Keys 3,6,7,'+',9,8,0,'=' with a model adder (1-cycle latency) -> number1=367, number2=980; one adder_enable pulse; display_value=1347; result_valid=1; busy high for 2-3 cycles.
- Keys 1,2,3,4 -> number1=123 (fourth digit ignored); then '+',5,'=' -> display_value=128.
- Keys 4,'=' -> number2=0, display_value=4. Then '=' again -> a second single enable pulse, result 4. Then digit 7 -> ENTRY_A with number1=7, result_valid=0.
- Adder never asserts valid after '=' -> error=1 exactly TIMEOUT_CYCLES cycles after entering WAIT; display_value=0; a clear key then sets error=0.
- Clear key presented in REQ -> adder_enable low after that edge and state ENTRY_A. Adder_valid asserted 1 cycle later -> ignored, display_value stays 0.
